mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: data_length, 32, data width; SHALL be 32 (four little-endian byte lanes).
REQ-002 Parameter: mem_length, 32, RAM depth in words; power of two, >=2; AW = $clog2(mem_length).
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: req_valid  in  1  request present.
REQ-006 Port: req_ready  out  1  unit can accept a request.
REQ-007 Port: req_we  in  1  0 = load, 1 = store.
REQ-008 Port: req_size  in  2  00 byte, 01 half, 10 word, 11 invalid.
REQ-009 Port: req_signed  in  1  sign-extend load result.
REQ-010 Port: req_addr  in  AW+2  byte address.
REQ-011 Port: req_wdata  in  32  store data, right-aligned.
REQ-012 Port: resp_valid  out  1  response present.
REQ-013 Port: resp_ready  in  1  consumer accepts response.
REQ-014 Port: resp_rdata  out  32  load result, zero for stores and errors.
REQ-015 Port: resp_err  out  1  misaligned or invalid-size request.
REQ-016 Port: ram_we  out  1  RAM write enable.
REQ-017 Port: ram_address  out  AW  RAM word address = captured req_addr[AW+1:2].
REQ-018 Port: ram_write_data  out  32  RAM write data.
REQ-019 Port: ram_read_data  in  32  RAM read data, valid one cycle after a read-cycle address (ram_we=0).

Function
REQ-020 FSM states: IDLE, RD, MERGE, WR, RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 IDLE with req_valid: capture we/size/signed/addr/wdata; next state RESP with err if size=11, half with addr[0]=1, or word with addr[1:0]!=0; else WR for word store; else RD.
REQ-022 RD: ram_we=0, ram_address driven; next MERGE.
REQ-023 MERGE load: select lane by addr[1:0] (byte) or addr[1] (half), zero- or sign-extend per req_signed, word passes unchanged; register into resp_rdata; next RESP.
REQ-024 MERGE sub-word store: ram_we=1, ram_write_data = ram_read_data with addressed lane(s) replaced by low byte/half of wdata; next RESP.
REQ-025 WR: ram_we=1, ram_write_data=wdata; next RESP.
REQ-026 RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_ready=1; then IDLE.
REQ-027 Latency from accept edge to resp_valid: error 1 cycle, word store 2, load 3, sub-word store 3; at most one request in flight.
REQ-028 Error responses SHALL NOT assert ram_we in any cycle; resp_rdata=0.
REQ-029 ram_we SHALL be 1 only in WR and MERGE-of-store and SHALL be forced 0 in any cycle rst=1.
REQ-030 req_valid outside IDLE is ignored; no request is dropped once accepted except by reset.

Reset
REQ-031 On rst at a clock edge: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, captured request registers=0, regardless of current state.
REQ-032 Reset mid-operation abandons the request with no response; RAM contents are not restored.

Structure
REQ-033 Package mem_pkg SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state enum.
REQ-034 Lane extract/insert logic SHALL be one combinational sub-module, byte_lane_unit, shared by load and store paths.

Verification
REQ-035 Word store 0xDEADBEEF @0x08, then unsigned word load @0x08 -> resp_rdata=0xDEADBEEF, err=0; store response 2 cycles, load 3 cycles after accept.
REQ-036 Word 0x11223344 @0x08, byte store 0xAA @0x09 -> RAM word 0x1122AA44; signed byte load @0x09 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-037 Word 0x8000AA44 @0x08, half load @0x0A signed -> 0xFFFF8000; unsigned -> 0x00008000.
REQ-038 Word load @0x06 and half load @0x03 -> resp_err=1, resp_rdata=0, ram_we never high, response 1 cycle after accept.
REQ-039 resp_ready=0 for 5 cycles in RESP while req_valid=1 -> resp_valid/resp_rdata stable, req_ready=0, new request accepted only after handshake.
REQ-040 rst asserted during MERGE of byte store -> ram_we=0 that cycle, IDLE next cycle, no resp_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states,
// and the alignment rule used to reject a request before touching the RAM.
package mem_pkg;

    typedef logic [1:0] size_t;

    localparam size_t SIZE_BYTE = 2'b00;
    localparam size_t SIZE_HALF = 2'b01;
    localparam size_t SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        MERGE = 3'd2,
        WR    = 3'd3,
        RESP  = 3'd4
    } state_t;

    // A request is rejected for an invalid size or a lane offset that does
    // not match the natural alignment of the access.
    function automatic logic req_is_bad(input size_t size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: req_is_bad = 1'b0;
            SIZE_HALF: req_is_bad = lane[0];
            SIZE_WORD: req_is_bad = (lane != 2'b00);
            default:   req_is_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane steering shared by the load and store paths: extracts
// and extends the addressed byte/half of a RAM word, and builds the merged
// word for sub-word stores.
module byte_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] ram_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_word,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load path: pick the addressed lane, then zero- or sign-extend it.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_word = 32'h0000_0000;
        case (lane)
            2'd0:    byte_sel = ram_word[7:0];
            2'd1:    byte_sel = ram_word[15:8];
            2'd2:    byte_sel = ram_word[23:16];
            default: byte_sel = ram_word[31:24];
        endcase
        half_sel = lane[1] ? ram_word[31:16] : ram_word[15:0];
        case (size)
            SIZE_BYTE: load_word = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_word = {{16{sign_ext & half_sel[15]}}, half_sel};
            SIZE_WORD: load_word = ram_word;
            default:   load_word = 32'h0000_0000;
        endcase
    end

    // Store path: overwrite only the addressed lane(s) of the current word.
    always_comb begin
        store_word = ram_word;
        case (size)
            SIZE_BYTE: begin
                case (lane)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            SIZE_WORD: store_word = wdata;
            default:   store_word = ram_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a synchronous word RAM.
// Sub-word stores are done as read-modify-write; misaligned or invalid
// requests are answered with an error without any RAM access.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int data_length = 32,
    parameter int mem_length  = 32,
    localparam int AW         = $clog2(mem_length)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_signed,
    input  logic [AW+1:0]          req_addr,
    input  logic [data_length-1:0] req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [data_length-1:0] resp_rdata,
    output logic                   resp_err,
    output logic                   ram_we,
    output logic [AW-1:0]          ram_address,
    output logic [data_length-1:0] ram_write_data,
    input  logic [data_length-1:0] ram_read_data
);

    state_t                 state;
    logic                   we_q;
    size_t                  size_q;
    logic                   signed_q;
    logic [AW+1:0]          addr_q;
    logic [data_length-1:0] wdata_q;

    logic [31:0] load_word;
    logic [31:0] store_word;

    byte_lane_unit u_lanes (
        .size       (size_q),
        .sign_ext   (signed_q),
        .lane       (addr_q[1:0]),
        .ram_word   (ram_read_data),
        .wdata      (wdata_q),
        .load_word  (load_word),
        .store_word (store_word)
    );

    assign req_ready   = (state == IDLE);
    assign ram_address = addr_q[AW+1:2];
    // store_word already equals wdata for full-word stores, so one mux feeds
    // both the WR and the read-modify-write cases.
    assign ram_write_data = store_word;
    // Gated by rst so an abandoned store can never reach the RAM.
    assign ram_we = !rst && ((state == WR) || (state == MERGE && we_q));

    // Request FSM: capture, optional RAM read, merge/extend, then hold response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        signed_q   <= req_signed;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        if (req_is_bad(req_size, req_addr[1:0])) begin
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && req_size == SIZE_WORD) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    state <= MERGE;
                end
                MERGE: begin
                    if (!we_q) resp_rdata <= load_word;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural RAM and a
// scoreboard-driven response monitor.
module tb_mem_access_unit;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [AW+1:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [AW-1:0] ram_address;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data = '0;

    mem_access_unit #(.data_length(32), .mem_length(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .ram_we         (ram_we),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM
    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        if (ram_we) mem[ram_address] <= ram_write_data;
        else        ram_read_data    <= mem[ram_address];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   n_issued = 0;
    logic we_seen = 1'b0;
    logic mon_first = 1'b1;
    logic [31:0] held_rdata;
    logic        held_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Response monitor: latency, hold stability, data/err and RAM-quiet errors
    always @(negedge clk) begin
        if (ram_we) we_seen = 1'b1;
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
            end else begin
                if (mon_first) begin
                    chk("latency", cyc - exp_q[0].acc + 1, exp_q[0].lat);
                    held_rdata = resp_rdata;
                    held_err   = resp_err;
                    mon_first  = 1'b0;
                end else begin
                    chk("hold_rdata", resp_rdata, held_rdata);
                    chk("hold_err", {31'd0, resp_err}, {31'd0, held_err});
                end
                if (resp_ready) begin
                    chk("rdata", resp_rdata, exp_q[0].rdata);
                    chk("err", {31'd0, resp_err}, {31'd0, exp_q[0].err});
                    if (exp_q[0].err) chk("err_no_ram_we", {31'd0, we_seen}, 32'd0);
                    void'(exp_q.pop_front());
                    mon_first = 1'b1;
                    done_cnt++;
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] rdata, input logic err, input int lat);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.lat   = lat;
        e.acc   = cyc;
        exp_q.push_back(e);
        n_issued++;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt < n_issued && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < n_issued) begin
            total++;
            bad++;
            $display("FAIL resp_timeout: got %0d responses expected %0d", done_cnt, n_issued);
        end
    endtask

    task automatic wait_ready(output logic ok);
        int n = 0;
        ok = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1");
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [6:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [6:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        logic ok;
        wait_ready(ok);
        if (ok) begin
            drive(we, size, sgn, addr, wdata);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            we_seen   = 1'b0;
            push_exp(exp_rdata, exp_err, lat);
            wait_done();
        end
    endtask

    initial begin
        logic ok;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;

        // Word store then word load
        issue(1, 2'b10, 0, 7'h08, 32'hDEADBEEF, 32'h0, 0, 2);
        issue(0, 2'b10, 0, 7'h08, 32'h0, 32'hDEADBEEF, 0, 3);

        // Byte store into a word, then signed / unsigned byte loads
        issue(1, 2'b10, 0, 7'h08, 32'h11223344, 32'h0, 0, 2);
        issue(1, 2'b00, 0, 7'h09, 32'h123456AA, 32'h0, 0, 3);
        chk("ram_word_byte_store", mem[2], 32'h1122AA44);
        issue(0, 2'b00, 1, 7'h09, 32'h0, 32'hFFFFFFAA, 0, 3);
        issue(0, 2'b00, 0, 7'h09, 32'h0, 32'h000000AA, 0, 3);

        // Half loads from the upper lane
        issue(1, 2'b10, 0, 7'h08, 32'h8000AA44, 32'h0, 0, 2);
        issue(0, 2'b01, 1, 7'h0A, 32'h0, 32'hFFFF8000, 0, 3);
        issue(0, 2'b01, 0, 7'h0A, 32'h0, 32'h00008000, 0, 3);

        // Back-pressure: response held while a second request waits
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        wait_ready(ok);
        if (ok) begin
            drive(0, 2'b10, 0, 7'h08, 32'h0);
            @(posedge clk);
            #1;
            we_seen = 1'b0;
            push_exp(32'h8000AA44, 0, 3);
            drive(0, 2'b00, 0, 7'h08, 32'h0);
            for (int i = 0; i < 7; i++) begin
                @(negedge clk);
                chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
            end
            chk("held_resp_valid", {31'd0, resp_valid}, 32'd1);
            @(posedge clk);
            #1;
            resp_ready = 1'b1;
            wait_ready(ok);
            if (ok) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                we_seen   = 1'b0;
                push_exp(32'h00000044, 0, 3);
            end
            wait_done();
        end

        // Error requests: misaligned word/half, invalid size, misaligned store
        issue(0, 2'b10, 0, 7'h06, 32'h0, 32'h0, 1, 1);
        issue(0, 2'b01, 0, 7'h03, 32'h0, 32'h0, 1, 1);
        issue(0, 2'b11, 0, 7'h08, 32'h0, 32'h0, 1, 1);
        issue(1, 2'b10, 0, 7'h09, 32'hCAFEF00D, 32'h0, 1, 1);
        chk("ram_word_after_err", mem[2], 32'h8000AA44);

        // Half store into upper lane, then mixed loads
        issue(1, 2'b01, 0, 7'h0A, 32'h7777BEEF, 32'h0, 0, 3);
        chk("ram_word_half_store", mem[2], 32'hBEEFAA44);
        issue(0, 2'b01, 0, 7'h0A, 32'h0, 32'h0000BEEF, 0, 3);
        issue(0, 2'b01, 1, 7'h08, 32'h0, 32'hFFFFAA44, 0, 3);
        issue(0, 2'b00, 1, 7'h0B, 32'h0, 32'hFFFFFFBE, 0, 3);
        issue(0, 2'b00, 1, 7'h08, 32'h0, 32'h00000044, 0, 3);

        // Reset during MERGE of a byte store
        wait_ready(ok);
        if (ok) begin
            drive(1, 2'b00, 0, 7'h0C, 32'h00000055);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk("rst_merge_ram_we", {31'd0, ram_we}, 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
            chk("post_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("post_rst_ram_word", mem[3], 32'h0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                chk("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
